cipher_byte_seq: RTL
====================

Name: cipher_byte_seq

Overview:
Upstream sequencer for the 8-bit stream_cipher core.
- Accepts plaintext or ciphertext bytes framed by a last flag on a valid/ready input.
- At the start of every frame it loads the per-frame seed into the cipher. It then issues one encrypt_en pulse per byte, waits the cipher latency, captures the result and presents it on a valid/ready output.
- Because the seed is reloaded per frame, the same block drives both encryption and decryption.

Parameters:
CIPHER_LAT, 1, cycles from the encrypt_en pulse until cipher_dout is valid (range 1..15).
SEED_W, 8, seed width; must match the cipher seed_in.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
s_valid  input  1  input byte valid.
s_ready  output  1  sequencer can accept a byte.
s_data  input  8  input byte.
s_last  input  1  byte is the final byte of its frame.
frame_seed  input  SEED_W  seed for the frame; sampled with the first byte of each frame.
load_seed  output  1  to cipher load_seed.
seed_out  output  SEED_W  to cipher seed_in.
encrypt_en  output  1  to cipher encrypt_en.
cipher_din  output  8  to cipher data_in.
cipher_dout  input  8  from cipher data_out.
m_valid  output  1  output byte valid.
m_ready  input  1  downstream accepts the byte.
m_data  output  8  processed byte.
m_last  output  1  processed byte ends its frame.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - All outputs are 0 except s_ready=1.
  - Held registers (data, last, seed, wait count) are cleared.
  - Asserting reset mid-frame abandons the frame; no partial output survives.
- FSM states: IDLE, SEED, ENC, WAIT, OUT, NEXT.
- IDLE: s_ready=1. On s_valid, latch s_data, s_last and frame_seed, then go to SEED.
- SEED: load_seed=1 for exactly one cycle, with seed_out equal to the latched seed. Go to ENC.
- ENC: encrypt_en=1 for exactly one cycle. Load the wait counter with CIPHER_LAT-1, then go to WAIT.
- WAIT: decrement the counter each cycle. When the counter is 0, register cipher_dout into m_data and last_r into m_last, then go to OUT. Total delay from the encrypt_en cycle to capture is CIPHER_LAT cycles.
- cipher_din: always driven from the held data register. It is stable from ENC through capture and otherwise holds its last value. seed_out likewise holds.
- OUT: m_valid=1, and m_data/m_last stay stable until m_ready=1. On the handshake, go to IDLE if m_last=1, otherwise go to NEXT.
- NEXT: s_ready=1. On s_valid, latch s_data and s_last and go to ENC; the seed is not reloaded and frame_seed is ignored.
- s_ready is 0 in SEED, ENC, WAIT and OUT. Input is never accepted while an output byte is pending.
- Throughput:
  - First byte of a frame: CIPHER_LAT+3 cycles, handshake to m_valid.
  - Subsequent bytes: CIPHER_LAT+2 cycles.
- Single-byte frame (s_last=1 on the first byte): SEED, ENC, WAIT, OUT, IDLE.
- m_ready held high: the OUT dwell is exactly 1 cycle.
- load_seed and encrypt_en are never high in the same cycle.

Optional Feature:
CIPHER_BYTE_SEQ_STATS_EN. When defined, add these ports:
- frame_len (16-bit output): count of bytes output in the last completed frame. Holds until the next frame completes; reset 0.
- frame_done (1-bit output): one-cycle pulse on the handshake of the m_last byte; reset 0.
- The byte counter saturates at 0xFFFF.

When not defined, neither port nor the counter exists, and the remaining behaviour is identical.

Decomposition:
- Package cipher_seq_pkg holds:
  - the state enum (IDLE, SEED, ENC, WAIT, OUT, NEXT);
  - the constants DATA_W=8 and CNT_W=4.
- One natural sub-module: cipher_lat_counter, a loadable down-counter with a zero flag used by WAIT.

Test Plan:
- Reset, then a bench stub cipher (dout = din XOR 0x5A after CIPHER_LAT=1, seed ignored). Send a single-byte frame 0x99 with last=1 and seed 0xD7 -> seed_out=0xD7 with a one-cycle load_seed, then one encrypt_en, then m_data=0xC3 and m_last=1; busy drops after the handshake.
- Three-byte frame 0x01, 0x02, 0x03 with m_ready always 1 -> exactly one load_seed; three encrypt_en pulses; outputs 0x5B, 0x58, 0x59 with m_last only on 0x59; spacing matches the throughput rule.
- Backpressure: m_ready held 0 for 5 cycles in OUT -> m_valid and m_data stable; s_ready=0 throughout; no extra encrypt_en.
- CIPHER_LAT=4 -> capture occurs exactly 4 cycles after the encrypt_en cycle; earlier cipher_dout values are ignored.
- Real stream_cipher, seed 0xA5, frame 0x10, 0x20 encrypted, then the outputs fed back as a second frame with the same seed -> recovers 0x10, 0x20.
- rst_n pulsed low during WAIT of byte 2 -> immediate IDLE with outputs 0 and s_ready=1. A new frame then starts with load_seed. With STATS_EN defined, frame_len reads 0 after the reset and 2 after a clean two-byte frame.

Source files
------------

// File: rtl/cipher_byte_seq_pkg.sv
// Shared types and constants for the cipher byte sequencer.
package cipher_seq_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEED = 3'd1,
    ENC  = 3'd2,
    WAIT = 3'd3,
    OUT  = 3'd4,
    NEXT = 3'd5
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cipher_byte_seq_lat_counter.sv
// Loadable down-counter with a zero flag; times the cipher latency in WAIT.
module cipher_lat_counter
  import cipher_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: the default assignment first keeps this always_comb from inferring a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: state updates use <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cipher_byte_seq.sv
// Sequencer feeding the 8-bit stream_cipher: reloads the seed per frame, one encrypt per byte.
// Optional frame statistics ports are enabled by defining CIPHER_BYTE_SEQ_STATS_EN.
module cipher_byte_seq
  import cipher_seq_pkg::*;
#(
  parameter int CIPHER_LAT = 1,
  parameter int SEED_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic [SEED_W-1:0] frame_seed,
  output logic              load_seed,
  output logic [SEED_W-1:0] seed_out,
  output logic              encrypt_en,
  output logic [DATA_W-1:0] cipher_din,
  input  logic [DATA_W-1:0] cipher_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy
`ifdef CIPHER_BYTE_SEQ_STATS_EN
  ,
  output logic [15:0]       frame_len,
  output logic              frame_done
`endif
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(CIPHER_LAT - 1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                last_q, last_d;
  logic [SEED_W-1:0]   seed_q, seed_d;
  logic [DATA_W-1:0]   mdata_q, mdata_d;
  logic                mlast_q, mlast_d;
  logic                cnt_zero;

  cipher_lat_counter u_lat_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (state_q == ENC),
    .load_val_i (LAT_LOAD),
    .dec_i      (state_q == WAIT),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    last_d  = last_q;
    seed_d  = seed_q;
    mdata_d = mdata_q;
    mlast_d = mlast_q;
    unique case (state_q)
      IDLE: if (s_valid) begin
        data_d  = s_data;
        last_d  = s_last;
        seed_d  = frame_seed;
        state_d = SEED;
      end
      SEED: state_d = ENC;
      ENC:  state_d = WAIT;
      WAIT: if (cnt_zero) begin
        mdata_d = cipher_dout;
        mlast_d = last_q;
        state_d = OUT;
      end
      OUT:  if (m_ready) state_d = mlast_q ? IDLE : NEXT;
      NEXT: if (s_valid) begin
        // Mid-frame bytes keep the running keystream: no seed reload.
        data_d  = s_data;
        last_d  = s_last;
        state_d = ENC;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: held data/seed registers are reset too, so an abandoned frame leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      last_q  <= 1'b0;
      seed_q  <= '0;
      mdata_q <= '0;
      mlast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      last_q  <= last_d;
      seed_q  <= seed_d;
      mdata_q <= mdata_d;
      mlast_q <= mlast_d;
    end
  end

  assign s_ready    = (state_q == IDLE) || (state_q == NEXT);
  assign load_seed  = (state_q == SEED);
  assign encrypt_en = (state_q == ENC);
  assign m_valid    = (state_q == OUT);
  assign busy       = (state_q != IDLE);
  assign seed_out   = seed_q;
  assign cipher_din = data_q;
  assign m_data     = mdata_q;
  assign m_last     = mlast_q;

`ifdef CIPHER_BYTE_SEQ_STATS_EN
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [15:0] frame_len_q, frame_len_d;
  logic        out_hs;

  assign out_hs = m_valid && m_ready;

  always_comb begin
    byte_cnt_d  = byte_cnt_q;
    frame_len_d = frame_len_q;
    if (out_hs) begin
      if (mlast_q) begin
        frame_len_d = sat_inc16(byte_cnt_q);
        byte_cnt_d  = '0;
      end else begin
        byte_cnt_d  = sat_inc16(byte_cnt_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q  <= '0;
      frame_len_q <= '0;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      frame_len_q <= frame_len_d;
    end
  end

  assign frame_len  = frame_len_q;
  assign frame_done = out_hs && mlast_q;
`endif

endmodule
